// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants and types for the write-back arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int c_ADDR_WIDTH = 5;
    localparam int c_DATA_WIDTH = 64;

    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] rd;
        logic [c_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Two-entry FIFO buffering ALU write-back requests.
// Revision    : 1.0  initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = c_ADDR_WIDTH + c_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = push_i && (count_q != 2'd2);
    assign w_pop  = pop_i  && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Round-robin merge of ALU and LSU results onto the register
//               file write port, with a per-register pending-write scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    input  logic                     mark_valid,
    input  logic [ADDR_WIDTH-1:0]    mark_rd,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [2**ADDR_WIDTH-1:0] busy,
    output logic                     idle
);

    localparam int c_NREGS = 2**ADDR_WIDTH;
    localparam int c_REQ_W = ADDR_WIDTH + DATA_WIDTH;

    logic [1:0]            w_fifo_count;
    logic [c_REQ_W-1:0]    w_fifo_head;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_fifo_has;
    logic                  w_push;
    logic                  w_grant_alu;
    logic                  w_grant_lsu;

    wb_src_e               last_grant_q, last_grant_d;
    logic                  rf_wen_q,     rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q,   rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q,   rf_wdata_d;
    logic [c_NREGS-1:0]    busy_q,       busy_d;

    // Readiness comes from registered occupancy only, never from this cycle's pop.
    assign alu_ready = (w_fifo_count != 2'd2);
    assign w_push    = alu_valid && alu_ready;

    wb_fifo #(
        .WIDTH (c_REQ_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i ({alu_rd, alu_data}),
        .pop_i       (w_grant_alu),
        .count_o     (w_fifo_count),
        .head_o      (w_fifo_head)
    );

    assign w_head_rd   = w_fifo_head[c_REQ_W-1 -: ADDR_WIDTH];
    assign w_head_data = w_fifo_head[DATA_WIDTH-1:0];
    assign w_fifo_has  = (w_fifo_count != 2'd0);

    // On a tie the source that did not win last time is granted.
    assign w_grant_alu = w_fifo_has && (!lsu_valid  || (last_grant_q == SRC_LSU));
    assign w_grant_lsu = lsu_valid  && (!w_fifo_has || (last_grant_q == SRC_ALU));
    assign lsu_ready   = w_grant_lsu;

    always_comb begin
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        busy_d       = busy_q;

        if (w_grant_alu) begin
            last_grant_d = SRC_ALU;
            rf_wen_d     = (w_head_rd != '0);
            rf_waddr_d   = w_head_rd;
            rf_wdata_d   = w_head_data;
        end else if (w_grant_lsu) begin
            last_grant_d = SRC_LSU;
            rf_wen_d     = (lsu_rd != '0);
            rf_waddr_d   = lsu_rd;
            rf_wdata_d   = lsu_data;
        end

        // Set after clear: a same-cycle mark belongs to a newer producer.
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (mark_valid && (mark_rd != '0)) begin
            busy_d[mark_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SRC_LSU;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;
    assign idle     = !w_fifo_has && !rf_wen_q;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed, self-checking bench for wb_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] busy;
    logic        idle;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .mark_valid (mark_valid),
        .mark_rd    (mark_rd),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .idle       (idle)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ldata;
        logic        mv;
        logic [4:0]  mrd;
        logic        e_aready;
        logic        e_lready;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [63:0] e_wdata;
        logic [31:0] e_busy;
        logic        e_idle;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid  = 1'b0; lsu_rd = '0; lsu_data = '0;
        mark_valid = 1'b0; mark_rd = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [63:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    initial begin
        //                av ard    adata  lv lrd   ldata   mv mrd  ar lr wen wa    wdata    busy   idle
        vecs[0]  = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0,    32'h8,   1'b1};
        vecs[1]  = '{1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0,    32'h8,   1'b0};
        vecs[2]  = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd3, 64'h11,   32'h28,  1'b0};
        vecs[3]  = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 64'h11,   32'h30,  1'b1};
        vecs[4]  = '{1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 64'h11,   32'h30,  1'b0};
        vecs[5]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd5, 64'h55,   1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 64'h55,   32'h30,  1'b0};
        vecs[6]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd6, 64'h66,   1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 64'h44,   32'h10,  1'b0};
        vecs[7]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd6, 64'h66,   1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 64'h66,   32'h0,   1'b0};
        vecs[8]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 64'hDEAD, 32'h200, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 64'h77,   1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 64'h77,   32'h280, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 64'h77,   32'h280, 1'b1};
        vecs[11] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 64'h77,   32'h280, 1'b1};

        // Reset state
        do_reset();
        chk("rst rf_wen",    64'(rf_wen),    64'h0);
        chk("rst rf_waddr",  64'(rf_waddr),  64'h0);
        chk("rst rf_wdata",  rf_wdata,       64'h0);
        chk("rst busy",      64'(busy),      64'h0);
        chk("rst alu_ready", 64'(alu_ready), 64'h1);
        chk("rst lsu_ready", 64'(lsu_ready), 64'h0);
        chk("rst idle",      64'(idle),      64'h1);

        // Stateful vector table, applied from reset
        for (int i = 0; i < 12; i++) begin
            drive_alu(vecs[i].av, vecs[i].ard, vecs[i].adata);
            drive_lsu(vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
            mark_valid = vecs[i].mv;
            mark_rd    = vecs[i].mrd;
            #1;
            chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_aready));
            chk($sformatf("v%0d lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].e_lready));
            tick();
            idle_inputs();
            chk($sformatf("v%0d rf_wen", i),   64'(rf_wen),   64'(vecs[i].e_wen));
            chk($sformatf("v%0d rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].e_waddr));
            chk($sformatf("v%0d rf_wdata", i), rf_wdata,      vecs[i].e_wdata);
            chk($sformatf("v%0d busy", i),     64'(busy),     64'(vecs[i].e_busy));
            chk($sformatf("v%0d idle", i),     64'(idle),     64'(vecs[i].e_idle));
        end

        // Contention straight after reset: ALU wins the first tie
        do_reset();
        drive_alu(1'b1, 5'd4, 64'h44);
        tick();
        drive_alu(1'b0, 5'd0, 64'h0);
        drive_lsu(1'b1, 5'd5, 64'h55);
        #1;
        chk("cont lsu_ready c1", 64'(lsu_ready), 64'h0);
        tick();
        chk("cont wen c1",   64'(rf_wen),   64'h1);
        chk("cont waddr c1", 64'(rf_waddr), 64'h4);
        chk("cont wdata c1", rf_wdata,      64'h44);
        chk("cont lsu_ready c2", 64'(lsu_ready), 64'h1);
        tick();
        drive_lsu(1'b0, 5'd0, 64'h0);
        chk("cont waddr c2", 64'(rf_waddr), 64'h5);
        chk("cont wdata c2", rf_wdata,      64'h55);
        tick();
        chk("cont wen c3",  64'(rf_wen), 64'h0);
        chk("cont idle c3", 64'(idle),   64'h1);

        // FIFO fill under LSU contention; blocked push accepted only after a pop
        do_reset();
        drive_alu(1'b1, 5'd1, 64'hA1);
        drive_lsu(1'b1, 5'd2, 64'hB2);
        #1;
        chk("full lready c0", 64'(lsu_ready), 64'h1);
        tick();
        chk("full waddr c0", 64'(rf_waddr), 64'h2);
        drive_alu(1'b1, 5'd3, 64'hA3);
        #1;
        chk("full lready c1", 64'(lsu_ready), 64'h0);
        tick();
        chk("full wdata c1", rf_wdata, 64'hA1);
        drive_alu(1'b1, 5'd4, 64'hA4);
        #1;
        chk("full aready c2", 64'(alu_ready), 64'h1);
        chk("full lready c2", 64'(lsu_ready), 64'h1);
        tick();
        chk("full waddr c2", 64'(rf_waddr), 64'h2);
        drive_alu(1'b1, 5'd5, 64'hA5);
        #1;
        chk("full aready c3", 64'(alu_ready), 64'h0);
        chk("full lready c3", 64'(lsu_ready), 64'h0);
        tick();
        chk("full wdata c3", rf_wdata, 64'hA3);
        drive_lsu(1'b0, 5'd0, 64'h0);
        #1;
        chk("full aready c4", 64'(alu_ready), 64'h1);
        tick();
        chk("full wdata c4", rf_wdata, 64'hA4);
        drive_alu(1'b0, 5'd0, 64'h0);
        tick();
        chk("full wen c5",   64'(rf_wen), 64'h1);
        chk("full wdata c5", rf_wdata,    64'hA5);
        tick();
        chk("full wen c6",  64'(rf_wen), 64'h0);
        chk("full idle c6", 64'(idle),   64'h1);

        // Reset mid-stream with a full FIFO and a busy bit set
        do_reset();
        drive_alu(1'b1, 5'd1, 64'hC1);
        drive_lsu(1'b1, 5'd2, 64'hD2);
        mark_valid = 1'b1; mark_rd = 5'd7;
        tick();
        mark_valid = 1'b0; mark_rd = 5'd0;
        drive_alu(1'b1, 5'd3, 64'hC3);
        tick();
        drive_alu(1'b1, 5'd4, 64'hC4);
        tick();
        idle_inputs();
        chk("mid pre aready", 64'(alu_ready), 64'h0);
        chk("mid pre busy",   64'(busy),      64'h80);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid aready", 64'(alu_ready), 64'h1);
        chk("mid busy",   64'(busy),      64'h0);
        chk("mid wen",    64'(rf_wen),    64'h0);
        chk("mid idle",   64'(idle),      64'h1);
        chk("mid waddr",  64'(rf_waddr),  64'h0);
        chk("mid wdata",  rf_wdata,       64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid stale wen %0d", k), 64'(rf_wen), 64'h0);
            chk($sformatf("mid idle %0d", k),      64'(idle),   64'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
